bg_rotation_ctrl: RTL and testbench

BG_ROTATION_CTRL -- requirements
Module: bg_rotation_ctrl

---
 rtl/bg_ctrl_pkg.sv | 32 +++
 rtl/step_edge_detect.sv | 27 ++
 rtl/bg_rotation_ctrl.sv | 144 ++++++++++++++
 tb/tb_bg_rotation_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bg_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bg_ctrl_pkg
// Brief    : Shared opcodes, state encoding and widths for the background
//            rotation controller.
// Revision : 1.0
// ============================================================================
package bg_ctrl_pkg;

    localparam int unsigned c_CNT_W          = 6;
    localparam int unsigned c_PERIOD_W       = 6;
    localparam int unsigned c_DEFAULT_PERIOD = 30;

    localparam logic [2:0] c_OP_NOP         = 3'd0;
    localparam logic [2:0] c_OP_SET_PERIOD  = 3'd1;
    localparam logic [2:0] c_OP_PAUSE       = 3'd2;
    localparam logic [2:0] c_OP_RESUME      = 3'd3;
    localparam logic [2:0] c_OP_STEP        = 3'd4;
    localparam logic [2:0] c_OP_REVERSE     = 3'd5;
    localparam logic [2:0] c_OP_RESET_PHASE = 3'd6;
    localparam logic [2:0] c_OP_RESERVED    = 3'd7;

    localparam logic [0:0] c_ST_RUN    = 1'b0;
    localparam logic [0:0] c_ST_PAUSED = 1'b1;

    // One rotation position in the given direction; 2-bit arithmetic wraps mod 4.
    function automatic logic [1:0] rot_step(input logic [1:0] rot, input logic dir);
        return dir ? (rot - 2'd1) : (rot + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : step_edge_detect
// Brief    : Rising-edge detector for the synchronous step button level.
// Revision : 1.0
// ============================================================================
module step_edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic r_prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= level;
        end
    end

    assign rise = level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/bg_rotation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bg_rotation_ctrl
// Brief    : Frame-synchronous quadrant colour rotation controller with a
//            one-deep host command slot and a step button.
// Revision : 1.0
// ============================================================================
module bg_rotation_ctrl
    import bg_ctrl_pkg::*;
#(
    parameter int unsigned DEFAULT_PERIOD = c_DEFAULT_PERIOD
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       frameStart,
    input  logic       cmdValid,
    output logic       cmdReady,
    input  logic [2:0] cmdOp,
    input  logic [5:0] cmdArg,
    input  logic       stepButton,
    output logic [1:0] rotationState,
    output logic       paused,
    output logic       direction,
    output logic       updated
);

    localparam logic [c_PERIOD_W-1:0] c_RST_PERIOD =
        (DEFAULT_PERIOD == 0) ? c_PERIOD_W'(1) : c_PERIOD_W'(DEFAULT_PERIOD);

    logic                  r_slot_full;
    logic [2:0]            r_slot_op;
    logic [5:0]            r_slot_arg;
    logic                  r_btn_pending;
    logic [0:0]            r_state;
    logic                  r_dir;
    logic [1:0]            r_rot;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_PERIOD_W-1:0] r_period;
    logic                  r_updated;

    logic                  w_btn_rise;
    logic                  w_accept;
    logic                  w_apply_host;
    logic                  w_apply_btn;
    logic [0:0]            w_state_nxt;
    logic                  w_dir_nxt;
    logic [1:0]            w_rot_nxt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [c_PERIOD_W-1:0] w_period_nxt;

    step_edge_detect u_step_edge_detect (
        .clock (clock),
        .reset (reset),
        .level (stepButton),
        .rise  (w_btn_rise)
    );

    assign w_accept     = cmdValid & ~r_slot_full;
    // The host slot always wins the frame; the button waits for a frame with no host command.
    assign w_apply_host = frameStart & r_slot_full;
    assign w_apply_btn  = frameStart & ~r_slot_full & r_btn_pending;

    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_rot_nxt    = r_rot;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period;
        if (w_apply_host) begin
            case (r_slot_op)
                c_OP_SET_PERIOD: begin
                    w_period_nxt = (r_slot_arg == 6'd0) ? 6'd1 : r_slot_arg;
                    w_cnt_nxt    = '0;
                end
                c_OP_PAUSE:  w_state_nxt = c_ST_PAUSED;
                c_OP_RESUME: w_state_nxt = c_ST_RUN;
                c_OP_STEP: begin
                    w_rot_nxt = rot_step(r_rot, r_dir);
                    w_cnt_nxt = '0;
                end
                c_OP_REVERSE: w_dir_nxt = ~r_dir;
                c_OP_RESET_PHASE: begin
                    w_rot_nxt = 2'd0;
                    w_cnt_nxt = '0;
                end
                default: ;
            endcase
        end else if (w_apply_btn) begin
            w_rot_nxt = rot_step(r_rot, r_dir);
            w_cnt_nxt = '0;
        end else if (frameStart && (r_state == c_ST_RUN)) begin
            if (r_cnt == (r_period - 6'd1)) begin
                w_cnt_nxt = '0;
                w_rot_nxt = rot_step(r_rot, r_dir);
            end else begin
                w_cnt_nxt = r_cnt + 6'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_slot_full   <= 1'b0;
            r_slot_op     <= c_OP_NOP;
            r_slot_arg    <= '0;
            r_btn_pending <= 1'b0;
            r_state       <= c_ST_RUN;
            r_dir         <= 1'b0;
            r_rot         <= 2'd0;
            r_cnt         <= '0;
            r_period      <= c_RST_PERIOD;
            r_updated     <= 1'b0;
        end else begin
            if (w_apply_host) begin
                r_slot_full <= 1'b0;
            end else if (w_accept) begin
                r_slot_full <= 1'b1;
                r_slot_op   <= cmdOp;
                r_slot_arg  <= cmdArg;
            end

            if (w_apply_btn) begin
                r_btn_pending <= 1'b0;
            end else if (w_btn_rise) begin
                r_btn_pending <= 1'b1;
            end

            r_state   <= w_state_nxt;
            r_dir     <= w_dir_nxt;
            r_rot     <= w_rot_nxt;
            r_cnt     <= w_cnt_nxt;
            r_period  <= w_period_nxt;
            r_updated <= (w_rot_nxt != r_rot);
        end
    end

    assign cmdReady      = ~r_slot_full;
    assign rotationState = r_rot;
    assign paused        = (r_state == c_ST_PAUSED);
    assign direction     = r_dir;
    assign updated       = r_updated;

endmodule
`default_nettype wire

// File: tb/tb_bg_rotation_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bg_rotation_ctrl
// Brief    : Directed self-checking bench for bg_rotation_ctrl.
// Revision : 1.0
// ============================================================================
module tb_bg_rotation_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       frameStart = 1'b0;
    logic       cmdValid = 1'b0;
    logic       cmdReady;
    logic [2:0] cmdOp = 3'd0;
    logic [5:0] cmdArg = 6'd0;
    logic       stepButton = 1'b0;
    logic [1:0] rotationState;
    logic       paused;
    logic       direction;
    logic       updated;

    int checks = 0;
    int errors = 0;

    bg_rotation_ctrl #(.DEFAULT_PERIOD(30)) dut (
        .clock         (clock),
        .reset         (reset),
        .frameStart    (frameStart),
        .cmdValid      (cmdValid),
        .cmdReady      (cmdReady),
        .cmdOp         (cmdOp),
        .cmdArg        (cmdArg),
        .stepButton    (stepButton),
        .rotationState (rotationState),
        .paused        (paused),
        .direction     (direction),
        .updated       (updated)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Idle cycle, then a one-cycle frameStart; returns just after the apply edge.
    task automatic frame();
        tick();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    task automatic send_cmd(input logic [2:0] op, input logic [5:0] arg);
        int n = 0;
        while (!cmdReady && n < 50) begin
            tick();
            n++;
        end
        check("slot_free_before_cmd", int'(cmdReady), 1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdArg   = arg;
        tick();
        cmdValid = 1'b0;
        cmdOp    = 3'd0;
        cmdArg   = 6'd0;
    endtask

    task automatic press_button();
        stepButton = 1'b1;
        tick();
        stepButton = 1'b0;
        tick();
    endtask

    initial begin
        int pulses;

        // Reset values
        #12;
        check("rst_rot", int'(rotationState), 0);
        check("rst_paused", int'(paused), 0);
        check("rst_dir", int'(direction), 0);
        check("rst_updated", int'(updated), 0);
        check("rst_ready", int'(cmdReady), 1);
        @(negedge clock);
        reset = 1'b1;

        // Default period: 30 frames per step, one updated pulse
        pulses = 0;
        for (int i = 0; i < 29; i++) begin
            frame();
            if (updated) pulses++;
        end
        check("rot_before_30th", int'(rotationState), 0);
        frame();
        if (updated) pulses++;
        check("rot_after_30th", int'(rotationState), 1);
        check("updated_pulses_30", pulses, 1);
        tick();
        check("updated_drops", int'(updated), 0);

        // SET_PERIOD 0 -> period 1
        send_cmd(3'd1, 6'd0);
        check("ready_low_after_accept", int'(cmdReady), 0);
        tick();
        check("ready_low_midframe", int'(cmdReady), 0);
        frame();
        check("ready_after_apply", int'(cmdReady), 1);
        check("rot_set_period_suppressed", int'(rotationState), 1);
        frame();
        check("rot_p1_a", int'(rotationState), 2);
        frame();
        check("rot_p1_b", int'(rotationState), 3);
        frame();
        check("rot_p1_wrap", int'(rotationState), 0);

        // Opcode 7 consumes the slot and suppresses counting
        send_cmd(3'd7, 6'd0);
        frame();
        check("op7_rot", int'(rotationState), 0);
        check("op7_ready", int'(cmdReady), 1);

        // PAUSE / button / RESUME with period 3
        send_cmd(3'd1, 6'd3);
        frame();
        frame();
        check("p3_cnt1_rot", int'(rotationState), 0);
        send_cmd(3'd2, 6'd0);
        frame();
        check("paused_set", int'(paused), 1);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            frame();
            if (updated) pulses++;
        end
        check("paused_rot_frozen", int'(rotationState), 0);
        check("paused_no_updates", pulses, 0);
        press_button();
        frame();
        check("paused_button_step", int'(rotationState), 1);
        check("paused_button_updated", int'(updated), 1);
        send_cmd(3'd3, 6'd0);
        frame();
        check("resumed", int'(paused), 0);
        frame();
        frame();
        check("resume_no_step_yet", int'(rotationState), 1);
        frame();
        check("resume_step_from_zero", int'(rotationState), 2);

        // RESET_PHASE, REVERSE, STEP, decrementing wrap
        send_cmd(3'd6, 6'd0);
        frame();
        check("reset_phase_rot", int'(rotationState), 0);
        check("reset_phase_dir", int'(direction), 0);
        send_cmd(3'd5, 6'd0);
        frame();
        check("reverse_dir", int'(direction), 1);
        check("reverse_rot", int'(rotationState), 0);
        send_cmd(3'd4, 6'd0);
        frame();
        check("step_down_wrap", int'(rotationState), 3);
        frame();
        frame();
        check("rev_no_step_yet", int'(rotationState), 3);
        frame();
        check("rev_auto_step", int'(rotationState), 2);

        // Host STEP and button on the same frame; second edge dropped
        send_cmd(3'd4, 6'd0);
        press_button();
        frame();
        check("host_first", int'(rotationState), 1);
        check("host_first_ready", int'(cmdReady), 1);
        press_button();
        frame();
        check("button_second", int'(rotationState), 0);
        frame();
        frame();
        check("dropped_edge", int'(rotationState), 0);

        // Reset with slot full and button pending
        send_cmd(3'd4, 6'd0);
        frame();
        check("pre_reset_rot", int'(rotationState), 3);
        send_cmd(3'd4, 6'd0);
        press_button();
        #2;
        reset = 1'b0;
        #1;
        check("midrst_rot", int'(rotationState), 0);
        check("midrst_dir", int'(direction), 0);
        check("midrst_paused", int'(paused), 0);
        check("midrst_updated", int'(updated), 0);
        check("midrst_ready", int'(cmdReady), 1);
        @(negedge clock);
        reset = 1'b1;
        frame();
        check("post_rst_no_step", int'(rotationState), 0);
        check("post_rst_no_update", int'(updated), 0);
        frame();
        check("post_rst_no_step2", int'(rotationState), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
